wb_stage: RTL



---
 rtl/wb_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: drives the single register-file write port from MEM/WB, splitting 64-bit products into LO then HI.
// Optional feature macro WB_PERF_CNT_EN adds write/stall performance counters.
module wb_stage #(
  parameter logic [5:0] HI_ADDR = 6'd32,
  parameter logic [5:0] LO_ADDR = 6'd33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MEM_WB_MemtoReg,
  input  logic        MEM_WB_RegWrite,
  input  logic        MEM_WB_MulWrite,
  input  logic [31:0] MEM_WB_dm_out,
  input  logic [31:0] MEM_WB_mux5_out,
  input  logic [5:0]  MEM_WB_mux1_out,
  input  logic [63:0] MEM_WB_prod,
`ifdef WB_PERF_CNT_EN
  output logic [31:0] wb_write_cnt,
  output logic [31:0] wb_stall_cnt,
`endif
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_stall
);

  typedef enum logic {
    IDLE   = 1'b0,
    MUL_HI = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] hi_hold;
  logic [31:0] next_hold;
  logic        next_we;
  logic [5:0]  next_waddr;
  logic [31:0] next_wdata;

  // Next-state and write-port selection; MUL_HI ignores inputs (they are the held multiply entry)
  always_comb begin
    next_state = state;
    next_hold  = hi_hold;
    next_we    = 1'b0;
    next_waddr = rf_waddr;
    next_wdata = rf_wdata;
    wb_stall   = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_WB_MulWrite) begin
          wb_stall   = ~reset;
          next_we    = 1'b1;
          next_waddr = LO_ADDR;
          next_wdata = MEM_WB_prod[31:0];
          next_hold  = MEM_WB_prod[63:32];
          next_state = MUL_HI;
        end else if (MEM_WB_RegWrite && (MEM_WB_mux1_out != 6'd0)) begin
          next_we    = 1'b1;
          next_waddr = MEM_WB_mux1_out;
          next_wdata = MEM_WB_MemtoReg ? MEM_WB_dm_out : MEM_WB_mux5_out;
        end else begin
          next_we    = 1'b0;
        end
      end
      MUL_HI: begin
        next_we    = 1'b1;
        next_waddr = HI_ADDR;
        next_wdata = hi_hold;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and registered write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hi_hold  <= 32'd0;
      rf_we    <= 1'b0;
      rf_waddr <= 6'd0;
      rf_wdata <= 32'd0;
    end else begin
      state    <= next_state;
      hi_hold  <= next_hold;
      rf_we    <= next_we;
      rf_waddr <= next_waddr;
      rf_wdata <= next_wdata;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Free-running wrap-around event counters, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_write_cnt <= 32'd0;
      wb_stall_cnt <= 32'd0;
    end else begin
      if (rf_we) begin
        wb_write_cnt <= wb_write_cnt + 32'd1;
      end
      if (wb_stall) begin
        wb_stall_cnt <= wb_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
